// File: rtl/cnn_mac_pkg.sv
// Shared types and helpers for the MAC operand feeder and its neighbours.
package cnn_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    WAIT_MAC,
    OUTPUT
  } feeder_state_e;

  function automatic int kernel_elems(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Kernel-load, window, MAC-side and result signals of the operand feeder.
// The slave modport is the feeder's view; master is the surrounding system's view.
interface mac_operand_feeder_if #(
  parameter int IN      = 8,
  parameter int OUT     = 32,
  parameter int N_ELEMS = 9
);
  logic                  kernel_load_valid_i;
  logic                  kernel_load_ready_o;
  logic [IN-1:0]         kernel_load_weight_i;
  logic [OUT-1:0]        kernel_load_bias_i;
  logic                  kernel_loaded_o;
  logic                  window_valid_i;
  logic                  window_ready_o;
  logic [N_ELEMS*IN-1:0] window_data_i;
  logic                  mac_operand_valid_o;
  logic [IN-1:0]         mac_feature_o;
  logic [IN-1:0]         mac_weight_o;
  logic [OUT-1:0]        mac_bias_o;
  logic                  mac_valid_i;
  logic [OUT-1:0]        mac_data_i;
  logic                  mac_ready_o;
  logic                  result_valid_o;
  logic [OUT-1:0]        result_data_o;
  logic                  result_ready_i;
  logic                  busy_o;

  modport slave (
    input  kernel_load_valid_i, kernel_load_weight_i, kernel_load_bias_i,
    input  window_valid_i, window_data_i, mac_valid_i, mac_data_i, result_ready_i,
    output kernel_load_ready_o, kernel_loaded_o, window_ready_o,
    output mac_operand_valid_o, mac_feature_o, mac_weight_o, mac_bias_o, mac_ready_o,
    output result_valid_o, result_data_o, busy_o
  );

  modport master (
    output kernel_load_valid_i, kernel_load_weight_i, kernel_load_bias_i,
    output window_valid_i, window_data_i, mac_valid_i, mac_data_i, result_ready_i,
    input  kernel_load_ready_o, kernel_loaded_o, window_ready_o,
    input  mac_operand_valid_o, mac_feature_o, mac_weight_o, mac_bias_o, mac_ready_o,
    input  result_valid_o, result_data_o, busy_o
  );
endinterface

// File: rtl/mac_kernel_regfile.sv
// Kernel storage: N weights plus one bias, single write port and an
// asynchronous read of the weight selected by the beat index.
module mac_kernel_regfile #(
  parameter int IN      = 8,
  parameter int OUT     = 32,
  parameter int N_ELEMS = 9,
  parameter int IDX_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             bias_we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [IN-1:0]    wr_weight_i,
  input  logic [OUT-1:0]   wr_bias_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [IN-1:0]    rd_weight_o,
  output logic [OUT-1:0]   bias_o
);

  logic [IN-1:0]  weight_q [N_ELEMS];
  logic [OUT-1:0] bias_q;

  // NOTE: the weight array is cleared on reset on purpose: a reset must leave no stale kernel
  // behind, so it is built from flops rather than a RAM macro that cannot be reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ELEMS; i++) weight_q[i] <= '0;
      bias_q <= '0;
    end else begin
      if (we_i)      weight_q[wr_idx_i] <= wr_weight_i;
      if (bias_we_i) bias_q             <= wr_bias_i;
    end
  end

  assign rd_weight_o = weight_q[rd_idx_i];
  assign bias_o      = bias_q;

endmodule

// File: rtl/mac_operand_feeder.sv
// Loads a kernel, streams one feature window to MAC_v2 one element per cycle,
// then captures the MAC result and hands it downstream on a valid/ready port.
module mac_operand_feeder
  import cnn_mac_pkg::*;
#(
  parameter int INPUT_BIT_RESOLUTION  = 8,
  parameter int OUTPUT_BIT_RESOLUTION = 32,
  parameter int KERNEL_SIZE_W         = 3,
  parameter int KERNEL_SIZE_H         = 3
) (
  input logic                 clk_i,
  input logic                 rst_i,
  mac_operand_feeder_if.slave bus
);

  localparam int IN    = INPUT_BIT_RESOLUTION;
  localparam int OUT   = OUTPUT_BIT_RESOLUTION;
  localparam int N     = kernel_elems(KERNEL_SIZE_W, KERNEL_SIZE_H);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  feeder_state_e          state_q, state_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic                   loaded_q, loaded_d;
  logic                   valid_q, valid_d;
  logic [N-1:0][IN-1:0]   window_q, window_d;
  logic [IN-1:0]          feature_q, feature_d;
  logic [IN-1:0]          weight_q, weight_d;
  logic [OUT-1:0]         result_q, result_d;

  logic                   rf_we, rf_bias_we, next_beat;
  logic [IN-1:0]          rf_weight;
  logic [OUT-1:0]         rf_bias;
  logic                   load_hs, window_hs;

  mac_kernel_regfile #(
    .IN      (IN),
    .OUT     (OUT),
    .N_ELEMS (N),
    .IDX_W   (CNT_W)
  ) u_regfile (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .we_i        (rf_we),
    .bias_we_i   (rf_bias_we),
    .wr_idx_i    (beat_q),
    .wr_weight_i (bus.kernel_load_weight_i),
    .wr_bias_i   (bus.kernel_load_bias_i),
    .rd_idx_i    (beat_d),
    .rd_weight_o (rf_weight),
    .bias_o      (rf_bias)
  );

  // Readies are forced low while reset is asserted so nothing handshakes into a clearing block.
  assign bus.kernel_load_ready_o = ~rst_i & ((state_q == IDLE) | (state_q == LOAD));
  assign bus.window_ready_o      = ~rst_i & (state_q == IDLE) & loaded_q & ~bus.kernel_load_valid_i;
  assign bus.mac_ready_o         = ~rst_i & (state_q == WAIT_MAC);
  assign load_hs   = bus.kernel_load_valid_i & bus.kernel_load_ready_o;
  assign window_hs = bus.window_valid_i & bus.window_ready_o;

  // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    loaded_d   = loaded_q;
    valid_d    = valid_q;
    window_d   = window_q;
    result_d   = result_q;
    rf_we      = 1'b0;
    rf_bias_we = 1'b0;
    next_beat  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_hs) begin
          rf_we      = 1'b1;
          rf_bias_we = 1'b1;
          loaded_d   = 1'b0;
          if (beat_q == LAST_BEAT) begin
            loaded_d = 1'b1;
          end else begin
            beat_d  = beat_q + ONE;
            state_d = LOAD;
          end
        end else if (window_hs) begin
          window_d  = bus.window_data_i;
          valid_d   = 1'b1;
          next_beat = 1'b1;
          beat_d    = '0;
          state_d   = STREAM;
        end
      end
      LOAD: begin
        if (load_hs) begin
          rf_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            loaded_d = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + ONE;
          end
        end
      end
      STREAM: begin
        if (beat_q == LAST_BEAT) begin
          valid_d = 1'b0;
          beat_d  = '0;
          state_d = WAIT_MAC;
        end else begin
          beat_d    = beat_q + ONE;
          next_beat = 1'b1;
        end
      end
      WAIT_MAC: begin
        if (bus.mac_valid_i & bus.mac_ready_o) begin
          result_d = bus.mac_data_i;
          state_d  = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bus.result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers load the element/weight about to be presented and otherwise hold.
  always_comb begin
    feature_d = feature_q;
    weight_d  = weight_q;
    if (next_beat) begin
      feature_d = (state_q == IDLE) ? bus.window_data_i[IN-1:0] : window_q[beat_d];
      weight_d  = rf_weight;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      loaded_q  <= 1'b0;
      valid_q   <= 1'b0;
      window_q  <= '0;
      feature_q <= '0;
      weight_q  <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      loaded_q  <= loaded_d;
      valid_q   <= valid_d;
      window_q  <= window_d;
      feature_q <= feature_d;
      weight_q  <= weight_d;
      result_q  <= result_d;
    end
  end

  assign bus.kernel_loaded_o     = loaded_q;
  assign bus.mac_operand_valid_o = valid_q;
  assign bus.mac_feature_o       = feature_q;
  assign bus.mac_weight_o        = weight_q;
  assign bus.mac_bias_o          = rf_bias;
  assign bus.result_valid_o      = (state_q == OUTPUT);
  assign bus.result_data_o       = result_q;
  assign bus.busy_o              = (state_q != IDLE);

endmodule
